face_box_tracker: RTL and testbench
===================================

Name: face_box_tracker

Overview:
- Downstream consumer of the pixel-processor controller's `enable` / `calibrateEnable` / `error` outputs.
- While calibrating, learns skin chroma bounds from a fixed central window.
- While enabled, classifies each pixel against those bounds and builds a per-frame bounding box of matching pixels.
- Publishes the box at end of frame for the blocking overlay stage.

Parameters:
- COORD_W, 10, width of pixel x/y coordinates (640x480 raster)
- CAL_X0, 280, calibration window left column (inclusive)
- CAL_X1, 359, calibration window right column (inclusive)
- CAL_Y0, 200, calibration window top row (inclusive)
- CAL_Y1, 279, calibration window bottom row (inclusive)
- MARGIN, 8, tolerance widening each learned bound, saturating at 0/255
- MIN_COUNT, 256, matched pixels required per frame for a valid box
- COUNT_W, 19, width of the per-frame match counter

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- enable  in  1  tracking enable from controller
- calibrate_enable  in  1  calibration enable from controller
- error  in  1  controller clear/error state; forces tracker idle
- frame_start  in  1  one-cycle pulse before first pixel of frame
- frame_end  in  1  one-cycle pulse on/after last pixel of frame
- pixel_valid  in  1  qualifies x, y, red, green, blue
- x  in  COORD_W  pixel column
- y  in  COORD_W  pixel row
- red, green, blue  in  8 each  pixel colour
- match_valid  out  1  pixel_valid delayed one cycle (TRACK only)
- match  out  1  delayed pixel classified as skin
- cal_empty  out  1  last calibration saw zero window pixels
- box_valid  out  1  published box is meaningful
- box_update  out  1  one-cycle pulse when box outputs change
- box_x0, box_x1, box_y0, box_y1  out  COORD_W each  published bounding box, inclusive

Behaviour:
- Reset (reset=0 at clk edge):
  - state=IDLE.
  - All outputs 0.
  - Bounds: min1=min2=255, max1=max2=0.
  - Accumulators cleared.
- Chroma:
  - d1 = red-green, d2 = red-blue, computed 9-bit signed.
  - Negative results clamp to 0. Range 0..255.
- States:
  - IDLE: if error=1, stay.
    - Else if calibrate_enable=1, go to CAL: min1=min2=255, max1=max2=0, cal_count cleared.
    - Else if enable=1, go to TRACK.
  - CAL: each pixel_valid pixel inside the window (inclusive bounds) updates min/max of d1 and d2, and increments a saturating 16-bit cal_count.
    - When calibrate_enable=0, latch thresholds and go to IDLE.
    - lo = max(min-MARGIN, 0), hi = min(max+MARGIN, 255).
    - cal_empty = (cal_count==0).
    - cal_empty=1 makes every later pixel classify as non-match.
  - TRACK: match = pixel_valid & !cal_empty & d1 in [lo1,hi1] & d2 in [lo2,hi2].
    - Registered: match and match_valid appear exactly one cycle after the pixel.
    - Matched pixels update frame_x0/x1/y0/y1 (x0/y0 start at all-ones, x1/y1 at 0) and increment a saturating count.
    - Leave TRACK when enable=0 or error=1.
- error=1 in any state:
  - Go to IDLE next cycle.
  - Clear box_valid and frame accumulators.
  - Retain learned thresholds and cal_empty.
- frame_start in TRACK clears the accumulators. A pixel in the same cycle counts toward the new frame.
- frame_end in TRACK publishes on the next cycle:
  - box_update=1 for one cycle.
  - box_valid = (count >= MIN_COUNT).
  - box coords = frame bounds if valid, else held at previous values.
  - A matching pixel in the same cycle as frame_end is included.
  - Accumulators then clear.
- frame_start and frame_end in the same cycle: publish first, then clear (equivalent).
- Leaving TRACK:
  - In-progress frame is discarded.
  - box_valid drops to 0 with a box_update pulse if it was 1.
  - match_valid=0.
- frame_start/frame_end outside TRACK are ignored.
- Outside TRACK, box_update may assert only on that exit pulse.
- calibrate_enable and enable both 1 in IDLE: calibrate_enable has priority.

Test Plan:
- Reset mid-CAL with reset=0 for 1 cycle → all outputs 0, state IDLE, next calibrate restarts from min=255/max=0.
- CAL window filled with (R,G,B)=(200,120,100), d1=80, d2=100; calibrate_enable falls → TRACK pixel (200,120,100) gives match=1 one cycle later; (200,170,100), d1=30, gives match=0; (200,130,100), d1=70 (inside 72..88? no) gives match=0; (200,114,100), d1=86, gives match=1.
- TRACK frame: 400 matching pixels in x 100..119, y 50..69, then frame_end → next cycle box_update=1, box_valid=1, box=(100,119,50,69).
- Frame with 100 matches (<MIN_COUNT) → box_update=1, box_valid=0, coords unchanged from prior frame.
- Calibration with no pixels in window → cal_empty=1; fully skin-coloured frame gives match=0 throughout, box_valid=0.
- error pulses mid-frame with box_valid=1 → box_valid=0 plus box_update pulse next cycle; remaining pixels give match_valid=0; thresholds survive re-entry to TRACK.

Source files
------------

// File: rtl/face_box_tracker.sv
// Skin-chroma bounding-box tracker: learns chroma bounds from a central window
// during calibration, then publishes a per-frame box of matching pixels.
module face_box_tracker #(
  parameter int COORD_W   = 10,
  parameter int CAL_X0    = 280,
  parameter int CAL_X1    = 359,
  parameter int CAL_Y0    = 200,
  parameter int CAL_Y1    = 279,
  parameter int MARGIN    = 8,
  parameter int MIN_COUNT = 256,
  parameter int COUNT_W   = 19
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               calibrate_enable,
  input  logic               error,
  input  logic               frame_start,
  input  logic               frame_end,
  input  logic               pixel_valid,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [7:0]         red,
  input  logic [7:0]         green,
  input  logic [7:0]         blue,
  output logic               match_valid,
  output logic               match,
  output logic               cal_empty,
  output logic               box_valid,
  output logic               box_update,
  output logic [COORD_W-1:0] box_x0,
  output logic [COORD_W-1:0] box_x1,
  output logic [COORD_W-1:0] box_y0,
  output logic [COORD_W-1:0] box_y1
);

  localparam logic [COORD_W-1:0] WX0  = COORD_W'(CAL_X0);
  localparam logic [COORD_W-1:0] WX1  = COORD_W'(CAL_X1);
  localparam logic [COORD_W-1:0] WY0  = COORD_W'(CAL_Y0);
  localparam logic [COORD_W-1:0] WY1  = COORD_W'(CAL_Y1);
  localparam logic [8:0]         MRG  = 9'(MARGIN);
  localparam logic [COUNT_W-1:0] MINC = COUNT_W'(MIN_COUNT);

  typedef enum logic [1:0] {S_IDLE, S_CAL, S_TRACK} state_t;

  state_t               state_q, state_d;
  logic [7:0]           min1_q, min1_d, max1_q, max1_d, min2_q, min2_d, max2_q, max2_d;
  logic [15:0]          cal_cnt_q, cal_cnt_d;
  logic [7:0]           lo1_q, lo1_d, hi1_q, hi1_d, lo2_q, lo2_d, hi2_q, hi2_d;
  logic                 cal_empty_q, cal_empty_d;
  logic [COORD_W-1:0]   fx0_q, fx0_d, fx1_q, fx1_d, fy0_q, fy0_d, fy1_q, fy1_d;
  logic [COUNT_W-1:0]   fcnt_q, fcnt_d;
  logic                 match_q, match_d, mvalid_q, mvalid_d;
  logic                 bvalid_q, bvalid_d, bupdate_q, bupdate_d;
  logic [COORD_W-1:0]   bx0_q, bx0_d, bx1_q, bx1_d, by0_q, by0_d, by1_q, by1_d;

  logic [7:0]           d1, d2;
  logic                 in_win, hit;
  logic [COORD_W-1:0]   ax0, ax1, ay0, ay1;
  logic [COUNT_W-1:0]   acnt;
  logic [8:0]           t_lo1, t_hi1, t_lo2, t_hi2;

  function automatic logic [7:0] chroma(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return diff[8] ? 8'd0 : diff[7:0];
  endfunction

  assign d1     = chroma(red, green);
  assign d2     = chroma(red, blue);
  assign in_win = pixel_valid && (x >= WX0) && (x <= WX1) && (y >= WY0) && (y <= WY1);
  assign hit    = pixel_valid && !cal_empty_q && (d1 >= lo1_q) && (d1 <= hi1_q)
                  && (d2 >= lo2_q) && (d2 <= hi2_q);

  // Widened thresholds; the 9th bit flags under/overflow so we can saturate.
  assign t_lo1 = {1'b0, min1_q} - MRG;
  assign t_lo2 = {1'b0, min2_q} - MRG;
  assign t_hi1 = {1'b0, max1_q} + MRG;
  assign t_hi2 = {1'b0, max2_q} + MRG;

  always_comb begin
    state_d     = state_q;
    min1_d      = min1_q;
    max1_d      = max1_q;
    min2_d      = min2_q;
    max2_d      = max2_q;
    cal_cnt_d   = cal_cnt_q;
    lo1_d       = lo1_q;
    hi1_d       = hi1_q;
    lo2_d       = lo2_q;
    hi2_d       = hi2_q;
    cal_empty_d = cal_empty_q;
    fx0_d       = fx0_q;
    fx1_d       = fx1_q;
    fy0_d       = fy0_q;
    fy1_d       = fy1_q;
    fcnt_d      = fcnt_q;
    match_d     = 1'b0;
    mvalid_d    = 1'b0;
    bvalid_d    = bvalid_q;
    bupdate_d   = 1'b0;
    bx0_d       = bx0_q;
    bx1_d       = bx1_q;
    by0_d       = by0_q;
    by1_d       = by1_q;
    ax0         = fx0_q;
    ax1         = fx1_q;
    ay0         = fy0_q;
    ay1         = fy1_q;
    acnt        = fcnt_q;

    case (state_q)
      S_IDLE: begin
        if (!error) begin
          if (calibrate_enable) begin
            state_d   = S_CAL;
            min1_d    = 8'hFF;
            min2_d    = 8'hFF;
            max1_d    = 8'h00;
            max2_d    = 8'h00;
            cal_cnt_d = '0;
          end else if (enable) begin
            state_d = S_TRACK;
          end
        end
      end

      S_CAL: begin
        if (error) begin
          state_d = S_IDLE;
        end else if (!calibrate_enable) begin
          state_d     = S_IDLE;
          lo1_d       = t_lo1[8] ? 8'd0 : t_lo1[7:0];
          lo2_d       = t_lo2[8] ? 8'd0 : t_lo2[7:0];
          hi1_d       = t_hi1[8] ? 8'hFF : t_hi1[7:0];
          hi2_d       = t_hi2[8] ? 8'hFF : t_hi2[7:0];
          cal_empty_d = (cal_cnt_q == '0);
        end else if (in_win) begin
          if (d1 < min1_q) min1_d = d1;
          if (d1 > max1_q) max1_d = d1;
          if (d2 < min2_q) min2_d = d2;
          if (d2 > max2_q) max2_d = d2;
          if (cal_cnt_q != '1) cal_cnt_d = cal_cnt_q + 16'd1;
        end
      end

      S_TRACK: begin
        if (error || !enable) begin
          state_d   = S_IDLE;
          bvalid_d  = 1'b0;
          bupdate_d = bvalid_q;
          fx0_d     = '1;
          fx1_d     = '0;
          fy0_d     = '1;
          fy1_d     = '0;
          fcnt_d    = '0;
        end else begin
          mvalid_d = pixel_valid;
          match_d  = hit;
          // With frame_end in the same cycle the old frame is published first.
          if (frame_start && !frame_end) begin
            ax0  = '1;
            ax1  = '0;
            ay0  = '1;
            ay1  = '0;
            acnt = '0;
          end
          if (hit) begin
            if (x < ax0) ax0 = x;
            if (x > ax1) ax1 = x;
            if (y < ay0) ay0 = y;
            if (y > ay1) ay1 = y;
            if (acnt != '1) acnt = acnt + 1'b1;
          end
          if (frame_end) begin
            bupdate_d = 1'b1;
            bvalid_d  = (acnt >= MINC);
            if (acnt >= MINC) begin
              bx0_d = ax0;
              bx1_d = ax1;
              by0_d = ay0;
              by1_d = ay1;
            end
            fx0_d  = '1;
            fx1_d  = '0;
            fy0_d  = '1;
            fy1_d  = '0;
            fcnt_d = '0;
          end else begin
            fx0_d  = ax0;
            fx1_d  = ax1;
            fy0_d  = ay0;
            fy1_d  = ay1;
            fcnt_d = acnt;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      min1_q      <= 8'hFF;
      min2_q      <= 8'hFF;
      max1_q      <= 8'h00;
      max2_q      <= 8'h00;
      cal_cnt_q   <= '0;
      lo1_q       <= '0;
      hi1_q       <= '0;
      lo2_q       <= '0;
      hi2_q       <= '0;
      cal_empty_q <= 1'b0;
      fx0_q       <= '1;
      fx1_q       <= '0;
      fy0_q       <= '1;
      fy1_q       <= '0;
      fcnt_q      <= '0;
      match_q     <= 1'b0;
      mvalid_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bupdate_q   <= 1'b0;
      bx0_q       <= '0;
      bx1_q       <= '0;
      by0_q       <= '0;
      by1_q       <= '0;
    end else begin
      state_q     <= state_d;
      min1_q      <= min1_d;
      min2_q      <= min2_d;
      max1_q      <= max1_d;
      max2_q      <= max2_d;
      cal_cnt_q   <= cal_cnt_d;
      lo1_q       <= lo1_d;
      hi1_q       <= hi1_d;
      lo2_q       <= lo2_d;
      hi2_q       <= hi2_d;
      cal_empty_q <= cal_empty_d;
      fx0_q       <= fx0_d;
      fx1_q       <= fx1_d;
      fy0_q       <= fy0_d;
      fy1_q       <= fy1_d;
      fcnt_q      <= fcnt_d;
      match_q     <= match_d;
      mvalid_q    <= mvalid_d;
      bvalid_q    <= bvalid_d;
      bupdate_q   <= bupdate_d;
      bx0_q       <= bx0_d;
      bx1_q       <= bx1_d;
      by0_q       <= by0_d;
      by1_q       <= by1_d;
    end
  end

  assign match_valid = mvalid_q;
  assign match       = match_q;
  assign cal_empty   = cal_empty_q;
  assign box_valid   = bvalid_q;
  assign box_update  = bupdate_q;
  assign box_x0      = bx0_q;
  assign box_x1      = bx1_q;
  assign box_y0      = by0_q;
  assign box_y1      = by1_q;

endmodule

// File: tb/tb_face_box_tracker.sv
// Bench for face_box_tracker: random calibration and frame traffic compared
// against a plain-arithmetic model of thresholds and bounding boxes.
module tb_face_box_tracker;
  logic       clk = 1'b0;
  logic       reset, enable, calibrate_enable, error, frame_start, frame_end, pixel_valid;
  logic [9:0] x, y;
  logic [7:0] red, green, blue;
  logic       match_valid, match, cal_empty, box_valid, box_update;
  logic [9:0] box_x0, box_x1, box_y0, box_y1;

  int n_checks = 0;
  int n_fail   = 0;
  int lo1, hi1, lo2, hi2;
  bit m_empty;
  int f_x0, f_x1, f_y0, f_y1, f_cnt;
  int b_x0, b_x1, b_y0, b_y1;
  bit b_valid;

  face_box_tracker dut (
    .clk(clk), .reset(reset), .enable(enable), .calibrate_enable(calibrate_enable),
    .error(error), .frame_start(frame_start), .frame_end(frame_end),
    .pixel_valid(pixel_valid), .x(x), .y(y), .red(red), .green(green), .blue(blue),
    .match_valid(match_valid), .match(match), .cal_empty(cal_empty),
    .box_valid(box_valid), .box_update(box_update),
    .box_x0(box_x0), .box_x1(box_x1), .box_y0(box_y0), .box_y1(box_y1)
  );

  always #5 clk = ~clk;

  function automatic int chroma(int a, int b);
    return (a > b) ? a - b : 0;
  endfunction

  function automatic bit is_skin(int r, int g, int b);
    int d1 = chroma(r, g);
    int d2 = chroma(r, b);
    return !m_empty && d1 >= lo1 && d1 <= hi1 && d2 >= lo2 && d2 <= hi2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic no_pixel();
    pixel_valid = 0; frame_start = 0; frame_end = 0;
  endtask

  task automatic put_pixel(int px, int py, int r, int g, int b);
    pixel_valid = 1; x = 10'(px); y = 10'(py);
    red = 8'(r); green = 8'(g); blue = 8'(b);
  endtask

  task automatic new_frame();
    f_x0 = 1023; f_x1 = 0; f_y0 = 1023; f_y1 = 0; f_cnt = 0;
  endtask

  task automatic m_add(int px, int py);
    f_cnt++;
    if (px < f_x0) f_x0 = px;
    if (px > f_x1) f_x1 = px;
    if (py < f_y0) f_y0 = py;
    if (py > f_y1) f_y1 = py;
  endtask

  task automatic test_reset();
    reset = 0; enable = 0; calibrate_enable = 0; error = 0; no_pixel();
    x = 0; y = 0; red = 0; green = 0; blue = 0;
    tick(); tick();
    n_checks++;
    if ({match_valid, match, cal_empty, box_valid, box_update} !== 5'b0 ||
        {box_x0, box_x1, box_y0, box_y1} !== 40'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got flags=%b box=%0d,%0d,%0d,%0d want all 0",
               {match_valid, match, cal_empty, box_valid, box_update}, box_x0, box_x1, box_y0, box_y1);
    end
    reset = 1; calibrate_enable = 1; tick();
    for (int i = 0; i < 10; i++) begin put_pixel(300 + i, 220, 10, 200, 200); tick(); end
    reset = 0; calibrate_enable = 0; put_pixel(310, 220, 200, 120, 100); tick();
    n_checks++;
    if ({match_valid, match, cal_empty, box_valid, box_update} !== 5'b0 ||
        {box_x0, box_x1, box_y0, box_y1} !== 40'b0) begin
      n_fail++;
      $display("FAIL reset_mid_cal got flags=%b want 00000", {match_valid, match, cal_empty, box_valid, box_update});
    end
    reset = 1; put_pixel(10, 10, 0, 0, 0); tick(); tick();
    n_checks++;
    if (match_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset match_valid got %b want 0", match_valid);
    end
    no_pixel();
    b_x0 = 0; b_x1 = 0; b_y0 = 0; b_y1 = 0; b_valid = 0;
  endtask

  task automatic test_calibrate(input int n_win, input bit rand_col);
    int mn1 = 255, mx1 = 0, mn2 = 255, mx2 = 0;
    int sw = 0, so = 0, px, py, r, g, b;
    enable = 0; calibrate_enable = 1; no_pixel(); tick();
    while (sw < n_win || so < 40) begin
      if (sw < n_win && (so >= 40 || $urandom_range(0, 2) != 0)) begin
        if (sw == 0) begin px = 280; py = 200; end
        else if (sw == 1) begin px = 359; py = 279; end
        else begin px = int'($urandom_range(280, 359)); py = int'($urandom_range(200, 279)); end
        if (rand_col) begin
          r = int'($urandom_range(170, 230));
          g = r - int'($urandom_range(60, 100));
          b = r - int'($urandom_range(80, 120));
        end else begin r = 200; g = 120; b = 100; end
        if (chroma(r, g) < mn1) mn1 = chroma(r, g);
        if (chroma(r, g) > mx1) mx1 = chroma(r, g);
        if (chroma(r, b) < mn2) mn2 = chroma(r, b);
        if (chroma(r, b) > mx2) mx2 = chroma(r, b);
        sw++;
      end else begin
        r = 255; g = 0; b = 0;
        case (so)
          0: begin px = 279; py = 240; end
          1: begin px = 360; py = 240; end
          2: begin px = 320; py = 199; end
          3: begin px = 320; py = 280; end
          default: begin
            r = int'($urandom_range(0, 255)); g = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
              px = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 279)) : int'($urandom_range(360, 639));
              py = int'($urandom_range(0, 479));
            end else begin
              px = int'($urandom_range(0, 639));
              py = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 199)) : int'($urandom_range(280, 479));
            end
          end
        endcase
        so++;
      end
      put_pixel(px, py, r, g, b); tick();
      n_checks++;
      if (match_valid !== 1'b0 || match !== 1'b0 || box_update !== 1'b0) begin
        n_fail++; $display("FAIL cal_outputs mv=%b m=%b upd=%b want 0,0,0", match_valid, match, box_update);
      end
    end
    no_pixel(); calibrate_enable = 0; tick();
    m_empty = (n_win == 0);
    lo1 = (mn1 - 8 < 0) ? 0 : mn1 - 8;
    lo2 = (mn2 - 8 < 0) ? 0 : mn2 - 8;
    hi1 = (mx1 + 8 > 255) ? 255 : mx1 + 8;
    hi2 = (mx2 + 8 > 255) ? 255 : mx2 + 8;
    n_checks++;
    if (cal_empty !== m_empty) begin
      n_fail++; $display("FAIL cal_empty got %b want %b", cal_empty, m_empty);
    end
  endtask

  task automatic enter_track();
    enable = 1; no_pixel(); tick();
  endtask

  task automatic test_spot_pixels();
    int g_tab[10] = '{120, 170, 130, 114, 128, 112, 129, 111, 120, 120};
    int b_tab[10] = '{100, 100, 100, 100, 100, 100, 100, 100, 108, 109};
    bit e_tab[10] = '{1, 0, 0, 1, 1, 1, 0, 0, 1, 0};
    for (int i = 0; i < 10; i++) begin
      put_pixel(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 200, g_tab[i], b_tab[i]);
      tick();
      n_checks++;
      if (match_valid !== 1'b1 || match !== e_tab[i]) begin
        n_fail++;
        $display("FAIL spot_pixel[%0d] g=%0d b=%0d got mv=%b m=%b want 1,%b", i, g_tab[i], b_tab[i], match_valid, match, e_tab[i]);
      end
    end
    no_pixel();
  endtask

  task automatic test_frame(input int n_reg, input int rx0, input int ry0, input int w,
                            input int n_noise, input bit rand_mode);
    int k = 0, sn = 0, px, py, r, g, b;
    bit exp_m, is_last;
    frame_start = 1; pixel_valid = 0; tick(); frame_start = 0;
    n_checks++;
    if (box_update !== 1'b0 || match_valid !== 1'b0) begin
      n_fail++; $display("FAIL frame_start upd=%b mv=%b want 0,0", box_update, match_valid);
    end
    new_frame();
    for (int i = 0; i < n_reg + n_noise; i++) begin
      is_last = (i == n_reg + n_noise - 1);
      if (k < n_reg && (sn >= n_noise || $urandom_range(0, 3) != 0)) begin
        if (rand_mode) begin
          px = int'($urandom_range(0, 639)); py = int'($urandom_range(0, 479));
          r = int'($urandom_range(160, 240));
          g = r - int'($urandom_range(40, 110));
          b = r - int'($urandom_range(60, 130));
        end else begin
          px = rx0 + k % w; py = ry0 + k / w; r = 200; g = 120; b = 100;
        end
        k++;
      end else begin
        px = int'($urandom_range(0, 639)); py = int'($urandom_range(0, 479));
        if (rand_mode) begin
          r = int'($urandom_range(0, 255)); g = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255));
        end else begin r = 50; g = 200; b = 200; end
        sn++;
      end
      if (!is_last && $urandom_range(0, 7) == 0) begin
        no_pixel(); tick();
        n_checks++;
        if (match_valid !== 1'b0 || match !== 1'b0 || box_update !== 1'b0) begin
          n_fail++; $display("FAIL frame_gap mv=%b m=%b upd=%b want 0,0,0", match_valid, match, box_update);
        end
      end
      exp_m = is_skin(r, g, b);
      if (exp_m) m_add(px, py);
      put_pixel(px, py, r, g, b); frame_end = is_last; tick();
      n_checks++;
      if (match_valid !== 1'b1 || match !== exp_m || box_update !== is_last) begin
        n_fail++;
        $display("FAIL frame_pixel (%0d,%0d) rgb=%0d,%0d,%0d got mv=%b m=%b upd=%b want 1,%b,%b",
                 px, py, r, g, b, match_valid, match, box_update, exp_m, is_last);
      end
    end
    no_pixel();
    b_valid = (f_cnt >= 256);
    if (b_valid) begin b_x0 = f_x0; b_x1 = f_x1; b_y0 = f_y0; b_y1 = f_y1; end
    n_checks++;
    if (box_valid !== b_valid || box_x0 !== 10'(b_x0) || box_x1 !== 10'(b_x1) ||
        box_y0 !== 10'(b_y0) || box_y1 !== 10'(b_y1)) begin
      n_fail++;
      $display("FAIL frame_box count=%0d got v=%b (%0d,%0d,%0d,%0d) want v=%b (%0d,%0d,%0d,%0d)", f_cnt,
               box_valid, box_x0, box_x1, box_y0, box_y1, b_valid, b_x0, b_x1, b_y0, b_y1);
    end
    tick();
    n_checks++;
    if (box_update !== 1'b0) begin
      n_fail++; $display("FAIL frame_update_pulse got %b want 0", box_update);
    end
  endtask

  task automatic test_error();
    bit had_valid = b_valid;
    frame_start = 1; tick(); frame_start = 0;
    for (int i = 0; i < 30; i++) begin put_pixel(400 + i, 400, 200, 120, 100); tick(); end
    error = 1;
    for (int i = 0; i < 3; i++) begin
      put_pixel(430 + i, 400, 200, 120, 100); tick();
      n_checks++;
      if (match_valid !== 1'b0 || box_valid !== 1'b0 || box_update !== ((i == 0) ? had_valid : 1'b0)) begin
        n_fail++;
        $display("FAIL error_cycle[%0d] mv=%b v=%b upd=%b want 0,0,%b", i, match_valid, box_valid, box_update,
                 (i == 0) ? had_valid : 1'b0);
      end
    end
    b_valid = 0;
    error = 0; no_pixel(); tick();
    new_frame();
    for (int i = 0; i < 20; i++) begin
      put_pixel(50 + i, 60, 200, 120, 100); frame_end = (i == 19);
      m_add(50 + i, 60); tick();
      n_checks++;
      if (match_valid !== 1'b1 || match !== is_skin(200, 120, 100)) begin
        n_fail++; $display("FAIL error_reentry mv=%b m=%b want 1,%b", match_valid, match, is_skin(200, 120, 100));
      end
    end
    no_pixel();
    n_checks++;
    if (box_update !== 1'b1 || box_valid !== 1'b0 || box_x0 !== 10'(b_x0) || box_x1 !== 10'(b_x1) ||
        box_y0 !== 10'(b_y0) || box_y1 !== 10'(b_y1)) begin
      n_fail++;
      $display("FAIL error_short_frame got upd=%b v=%b (%0d,%0d,%0d,%0d) want 1,0 (%0d,%0d,%0d,%0d)",
               box_update, box_valid, box_x0, box_x1, box_y0, box_y1, b_x0, b_x1, b_y0, b_y1);
    end
  endtask

  task automatic test_exit();
    bit had_valid = b_valid;
    enable = 0; no_pixel(); tick();
    n_checks++;
    if (box_update !== had_valid || box_valid !== 1'b0 || match_valid !== 1'b0) begin
      n_fail++; $display("FAIL exit_track upd=%b v=%b mv=%b want %b,0,0", box_update, box_valid, match_valid, had_valid);
    end
    b_valid = 0;
    tick();
    n_checks++;
    if (box_update !== 1'b0) begin
      n_fail++; $display("FAIL exit_idle_update got %b want 0", box_update);
    end
  endtask

  initial begin
    test_reset();
    test_calibrate(200, 1'b0);
    enter_track();
    test_spot_pixels();
    test_frame(400, 100, 50, 20, 60, 1'b0);
    test_frame(100, 300, 300, 10, 50, 1'b0);
    test_frame(400, 500, 20, 20, 40, 1'b0);
    test_error();
    test_exit();
    test_calibrate(300, 1'b1);
    enter_track();
    for (int i = 0; i < 4; i++) test_frame(500, 0, 0, 1, 100, 1'b1);
    test_exit();
    test_calibrate(0, 1'b0);
    enter_track();
    test_frame(300, 200, 200, 20, 0, 1'b0);
    test_exit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout after 2 ms of simulated time");
    $fatal(1, "timeout");
  end
endmodule
